// File: rtl/seg_pkg.sv
// Shared digit-code and segment-pattern definitions for the seven-segment scan driver.
package seg_pkg;

  typedef logic [6:0] seg_t;  // active-low, bit 0 = a ... bit 6 = g

  localparam logic [3:0] ZERO  = 4'd0;
  localparam logic [3:0] ONE   = 4'd1;
  localparam logic [3:0] TWO   = 4'd2;
  localparam logic [3:0] THREE = 4'd3;
  localparam logic [3:0] FOUR  = 4'd4;
  localparam logic [3:0] FIVE  = 4'd5;
  localparam logic [3:0] SIX   = 4'd6;
  localparam logic [3:0] SEVEN = 4'd7;
  localparam logic [3:0] EIGHT = 4'd8;
  localparam logic [3:0] NINE  = 4'd9;
  localparam logic [3:0] NULL  = 4'b1111;

  localparam seg_t BLANK = 7'b1111111;
  localparam seg_t DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low seven-segment pattern decoder.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = DASH;
    case (code_i)
      ZERO:    seg_o = 7'b1000000;
      ONE:     seg_o = 7'b1111001;
      TWO:     seg_o = 7'b0100100;
      THREE:   seg_o = 7'b0110000;
      FOUR:    seg_o = 7'b0011001;
      FIVE:    seg_o = 7'b0010010;
      SIX:     seg_o = 7'b0000010;
      SEVEN:   seg_o = 7'b1111000;
      EIGHT:   seg_o = 7'b0000000;
      NINE:    seg_o = 7'b0010000;
      NULL:    seg_o = BLANK;
      default: seg_o = DASH;  // 4'hA..4'hE flag a bad code upstream
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit time-multiplexed seven-segment scan driver with per-frame shadow capture.
// Optional build macro ZERO_BLANK_EN: leading zeros are stored as blanks at frame reload.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIG_PERIOD   = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] dig_0,
  input  logic [3:0] dig_1,
  input  logic [3:0] dig_2,
  input  logic [3:0] dig_3,
  output logic [3:0] an,
  output seg_t       seg,
  output logic       frame_done
);

  localparam int CW = (DIG_PERIOD > 1) ? $clog2(DIG_PERIOD) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(DIG_PERIOD - 1);
  localparam logic [CW-1:0] CYC_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]    slot_q, slot_d;
  logic [3:0]    shadow_q [4];
  logic [3:0]    din      [4];
  logic [3:0]    load_d   [4];
  logic [3:0]    an_q, an_d;
  seg_t          seg_q, seg_d;
  logic          frame_done_q;
  logic          slot_end, frame_end, blank_now;
  seg_t          dec_seg;

  assign din[0] = dig_0;
  assign din[1] = dig_1;
  assign din[2] = dig_2;
  assign din[3] = dig_3;

  assign slot_end  = enable && (cyc_q == CYC_LAST);
  assign frame_end = slot_end && (slot_q == 2'd3);

  always_comb begin
    cyc_d  = cyc_q;
    slot_d = slot_q;
    if (enable) begin
      cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + 1'b1;
      if (slot_end) slot_d = slot_q + 2'd1;
    end
  end

`ifdef ZERO_BLANK_EN
  // Walk from the leftmost digit; blank zeros until the first real digit.
  always_comb begin
    logic lead;
    lead = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      load_d[k] = din[k];
      if (lead && k != 0) begin
        if (din[k] == ZERO)      load_d[k] = NULL;
        else if (din[k] != NULL) lead = 1'b0;
      end
    end
  end
`else
  for (genvar gi = 0; gi < 4; gi++) begin : g_load
    assign load_d[gi] = din[gi];
  end
`endif

  seg7_decode u_decode (
    .code_i (shadow_q[slot_q]),
    .seg_o  (dec_seg)
  );

  assign blank_now = !enable || (cyc_q < CYC_BLANK);

  always_comb begin
    an_d  = 4'b1111;
    seg_d = BLANK;
    if (!blank_now) begin
      an_d  = ~(4'b0001 << slot_q);
      seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q        <= '0;
      slot_q       <= 2'd0;
      an_q         <= 4'b1111;
      seg_q        <= BLANK;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 4; k++) shadow_q[k] <= NULL;
    end else begin
      cyc_q        <= cyc_d;
      slot_q       <= slot_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_end;
      if (frame_end) begin
        for (int k = 0; k < 4; k++) shadow_q[k] <= load_d[k];
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed four-digit seven-segment scan driver, directly downstream of the banner digit generator. It captures the four 4-bit digit codes once per display frame into shadow registers, then drives one common-anode digit at a time. Each digit slot starts with a ghost-suppression blanking interval. The block feeds the board's active-low anode and segment pins.

## Interface
- DIG_PERIOD, 50000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; must be < DIG_PERIOD.
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset; one clock, asynchronous active-low reset.
- enable  input  1  high = scanning runs; low = counter and slot freeze, anodes forced off.
- dig_0  input  4  rightmost digit code (0–9, 4'b1111 = blank).
- dig_1  input  4  digit code, second from right.
- dig_2  input  4  digit code, third from right.
- dig_3  input  4  leftmost digit code.
- an  output  4  active-low anode enables; an[k] drives the position of dig_k.
- seg  output  7  active-low segments; seg[0]=a … seg[6]=g.
- frame_done  output  1  one-cycle pulse when the shadow registers reload.

## Operation
- State:
  - cyc counter, width clog2(DIG_PERIOD), counts 0..DIG_PERIOD-1 and wraps.
  - slot, 2 bits, scan order 0→1→2→3→0.
  - shadow[3:0], 4 bits each.
- Advance: when enable is high and cyc == DIG_PERIOD-1, cyc returns to 0 and slot increments (3 wraps to 0).
- Frame reload: when slot == 3 and cyc == DIG_PERIOD-1 with enable high, shadow[k] <= dig_k and frame_done pulses.
  - Inputs are sampled only at this boundary; mid-frame input changes never tear the display.
- Drive:
  - enable low or cyc < BLANK_CYCLES: an = 4'b1111, seg = 7'b1111111.
  - Otherwise: an = ~(4'b0001 << slot), seg = decode(shadow[slot]).
- Decode (active-low, g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - 4'b1111 = 1111111 (blank)
  - 4'b1010–4'b1110 = 0111111 (dash, error indication)
- Never more than one anode low in any cycle.

## Timing
- Reset values: cyc = 0, slot = 0, shadow = 4'b1111 ×4, an = 4'b1111, seg = 7'b1111111, frame_done = 0.
- an, seg and frame_done are registered. They reflect the cyc/slot/shadow state of the previous cycle (1-cycle latency).
- First frame after reset shows blanks. Inputs first appear in slot 0 after 4×DIG_PERIOD cycles.
- frame_done is high for exactly one cycle, the cycle after the reload edge. The new shadow values are visible from that same cycle.
- enable deassert: counter and slot hold their values, and an goes to 1111 on the next cycle. Re-assert resumes from the held cyc value; no reload occurs while enable is low.
- reset_n asserted mid-slot: all state and outputs return to reset values immediately (asynchronously). Operation restarts at slot 0, cyc 0.
- Refresh rate = f_clk / (4×DIG_PERIOD); 250 Hz at 50 MHz with defaults.

## Configuration
- ZERO_BLANK_EN defined: at frame reload, leading zeros are stored as 4'b1111.
  - Scan runs from dig_3 downward and stops at the first code that is not 0 and not 4'b1111.
  - dig_0 is never blanked.
  - Example: inputs 0,0,4,0 (dig_3..dig_0) load as F,F,4,0.
- Undefined: shadow loads the inputs verbatim and zeros display.

## Structure
- Package seg_pkg:
  - digit code constants: ZERO..NINE, NULL = 4'b1111.
  - the seven-segment pattern constants: BLANK and DASH.
  - type for the 7-bit segment vector.
- Sub-module seg7_decode: purely combinational, 4-bit code in, 7-bit active-low pattern out. Instantiated once on the muxed shadow[slot].
- seg_scan owns the counter, slot, shadow registers, blanking and output registers.

## Test plan
- Reset, then dig_3..dig_0 = 1,2,3,4, DIG_PERIOD = 8, BLANK_CYCLES = 2 -> first frame all blank. Next frame: an = 1110 with seg = 0011001 (4), then 1101 with 0110000 (3), then 1011 / 0100100, then 0111 / 1111001. Each anode is low 6 of 8 cycles.
- Change inputs to 9,9,9,9 during slot 1 -> the displayed digits are unchanged until the frame_done pulse. frame_done is high for one cycle after the slot-3 final cycle.
- Input codes 4'hA and 4'hF -> seg = 0111111 and 1111111 respectively.
- Deassert enable for 20 cycles mid-slot -> an = 1111 throughout and cyc is held. After re-assert, the slot completes its remaining cycles, with no frame_done during the freeze.
- Assert reset_n low mid-slot, asynchronous to clk -> an = 1111 and seg = 1111111 before the next clk edge. Shadow returns to blank.
- With ZERO_BLANK_EN, inputs 0,0,0,0 -> positions 3..1 blank, position 0 shows 1000000. Inputs 0,5,0,7 -> displayed as blank,5,0,7.
